// File: rtl/nibble_serial_subtr_if.sv
// Operand/result bus between the operand source and the nibble-serial subtractor.
// SERIAL_SUBTR_OVF_EN adds the signed-overflow flag to the bus.
interface nibble_serial_subtr_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
`ifdef SERIAL_SUBTR_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_SUBTR_OVF_EN
    modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout, zero);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero);
`endif
endinterface

// File: rtl/nibble_serial_subtr.sv
// Multi-nibble subtractor: a - b - bin computed one nibble per clock, LSB first.
// Optional signed-overflow flag enabled by SERIAL_SUBTR_OVF_EN.
module nibble_serial_subtr #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_serial_subtr_if.slave   sub_if
);
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               br_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               zero_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [4:0]         sub5;
    logic               br_d;
    logic [WIDTH-1:0]   diff_d;
    logic               last_nib;

    // Nibble borrow-chain step for the current cnt, merged into the result word
    always_comb begin
        a_sh     = a_q >> {cnt_q, 2'b00};
        b_sh     = b_q >> {cnt_q, 2'b00};
        sub5     = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - 5'(br_q);
        br_d     = sub5[4];
        last_nib = (cnt_q == CNT_W'(NIB - 1));
        diff_d   = diff_q;
        for (int i = 0; i < int'(NIB); i++) begin
            if (cnt_q == CNT_W'(i)) begin
                diff_d[4*i +: 4] = sub5[3:0];
            end
        end
    end

`ifdef SERIAL_SUBTR_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
    assign sub_if.ovf = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && sub_if.start) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_nib) begin
            ovf_q <= ovf_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sub_if.start) begin
                        a_q     <= sub_if.a;
                        b_q     <= sub_if.b;
                        br_q    <= sub_if.bin;
                        diff_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    diff_q <= diff_d;
                    br_q   <= br_d;
                    if (last_nib) begin
                        bout_q  <= br_d;
                        zero_q  <= (diff_d == '0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sub_if.busy = busy_q;
    assign sub_if.done = done_q;
    assign sub_if.diff = diff_q;
    assign sub_if.bout = bout_q;
    assign sub_if.zero = zero_q;

endmodule

// File: doc/nibble_serial_subtr.md
Name: nibble_serial_subtr

Overview:
Multi-nibble subtractor controller. It computes a WIDTH-bit difference a - b - bin one 4-bit nibble per clock, LSB nibble first. A registered borrow links the nibble steps, so a narrow borrow-chain datapath is reused across the whole word. It sits between the operand source (switch/register front end) and the result display/consumer, and returns the difference, borrow-out and status flags with a start/done handshake.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, number of nibble steps (derived localparam, not overridable).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request a new operation; sampled only in IDLE.
a  input  WIDTH  minuend; latched on the accepted start.
b  input  WIDTH  subtrahend; latched on the accepted start.
bin  input  1  borrow-in to the LSB nibble; latched on the accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse when the result is valid.
diff  output  WIDTH  difference, registered; holds until the next accepted start.
bout  output  1  borrow-out of the MSB nibble, registered; holds.
zero  output  1  high when diff == 0, registered; holds.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: state=IDLE, cnt=0, borrow register=0, operand registers=0, diff=0, bout=0, zero=0, busy=0, done=0. Reset wins over every other event, including mid-RUN; a partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch a, b, bin (bin goes into the borrow register);
  - clear diff to 0;
  - set cnt=0 and go to RUN.
- IDLE with start=0: no change; outputs hold.
- RUN: each edge processes nibble i=cnt.
  - Compute {br_next, d} = a[4i+3:4i] - b[4i+3:4i] - br, 5-bit arithmetic.
  - br_next=1 iff a_nib < b_nib + br.
  - d is the low 4 bits and is written to diff[4i+3:4i]; br <= br_next.
  - If cnt==NIB-1: bout <= br_next, zero <= (the completed diff == 0), go to DONE. Otherwise cnt <= cnt+1.
- DONE: done=1 for exactly this one cycle; the next edge goes to IDLE unconditionally.
- Latency: the start is accepted at edge k; done is high in the cycle following edge k+NIB. Back-to-back start is possible starting the cycle after done.
- start is ignored in RUN and DONE; no queueing, and the operand registers are unaffected by input changes during RUN.
- diff may show partial nibbles during RUN; consumers use it only when done=1, or in IDLE after a completed operation.
- Wrap-around: the result is modulo 2^WIDTH; bout=1 flags unsigned underflow (a < b + bin).
- cnt width is clog2(NIB), minimum 1.

Optional Feature:
Macro SERIAL_SUBTR_OVF_EN.
- Defined: adds output port ovf (1 bit). It is registered alongside bout and holds until the next accepted start.
  - ovf = two's-complement signed overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
  - Reset value 0; cleared on an accepted start.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x0234, bin=0, start pulse -> done exactly 4 cycles after the accepting edge; diff=0x1000, bout=0, zero=0.
2. a=0x1000, b=0x0001, bin=0 -> diff=0x0FFF, bout=0 (borrow ripples through 3 nibbles). Then a=0x0000, b=0x0001 -> diff=0xFFFF, bout=1.
3. a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1. Then a=0xABCD, b=0xABCD, bin=0 -> diff=0x0000, zero=1, bout=0.
4. Hold start=1 continuously with changing a/b during RUN -> only the first operands are used; a new operation begins on the edge after done (IDLE), and done pulses are exactly 1 cycle wide.
5. Assert rst for 1 cycle at cnt=2 of an operation -> next cycle busy=0, done=0, diff=0, bout=0, zero=0; no done pulse for the aborted operation.
6. With SERIAL_SUBTR_OVF_EN: a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0. a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1. a=0x0003, b=0x0001 -> ovf=0.
